// File: rtl/isp_axi_pkg.sv
// Shared FSM encoding and AXI4 constants for the ISP frame writer.
// Build option ISP_MAXI_WR_ERR_EN is consumed by isp_maxi_wr.
package isp_axi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP,
        S_DONE
    } wr_state_t;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [3:0] AXI_CACHE_BUF   = 4'b0010;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    // SLVERR and DECERR both carry bit 1
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/isp_edge_det.sv
// Two-flop start chain with rising-edge detect for the frame writer.
module isp_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise
);

    logic s1;
    logic s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= level;
            s2 <= s1;
        end
    end

    assign rise = s1 & ~s2;

endmodule

// File: rtl/isp_maxi_wr.sv
// AXI4 master that streams one frame from a FWFT FIFO as fixed INCR bursts.
// Define ISP_MAXI_WR_ERR_EN to latch BRESP errors and abort the frame.
module isp_maxi_wr
    import isp_axi_pkg::*;
#(
    parameter C_M_TARGET_SLAVE_BASE_ADDR = 32'h40000000,
    parameter int C_M_AXI_BURST_LEN      = 256,
    parameter int C_M_AXI_ADDR_WIDTH     = 32,
    parameter int C_M_AXI_DATA_WIDTH     = 64
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,
    input  logic                            WRITE_START,
    input  logic [31:0]                     BURST_ONE_FRAME_TOTAL,
    output logic                            WRITE_DONE,
    output logic                            WRITE_ERR,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   rd_data,
    output logic                            r_en,
    input  logic                            empty_n,
    output logic                            M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [7:0]                      M_AXI_AWLEN,
    output logic [2:0]                      M_AXI_AWSIZE,
    output logic [1:0]                      M_AXI_AWBURST,
    output logic                            M_AXI_AWLOCK,
    output logic [3:0]                      M_AXI_AWCACHE,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WLAST,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam logic [AW-1:0] BASE_ADDR = AW'(C_M_TARGET_SLAVE_BASE_ADDR);
    localparam logic [AW-1:0] BURST_BYTES =
        AW'(C_M_AXI_BURST_LEN * C_M_AXI_DATA_WIDTH / 8);
    localparam logic [7:0] LAST_BEAT = 8'(C_M_AXI_BURST_LEN - 1);

    wr_state_t     state;
    logic [7:0]    beat;
    logic [31:0]   burst_cnt;
    logic [31:0]   total_q;
    logic [AW-1:0] offset;
    logic          awvalid_q;
    logic          bready_q;
    logic          done_q;
    logic          err_q;
    logic          start_rise;
    logic          in_data;
    logic          last_beat;
    logic          w_hs;
    logic          b_fail;

    isp_edge_det u_start (
        .clk   (M_AXI_ACLK),
        .rst_n (M_AXI_ARESETN),
        .level (WRITE_START),
        .rise  (start_rise)
    );

`ifdef ISP_MAXI_WR_ERR_EN
    assign b_fail    = resp_is_err(M_AXI_BRESP);
    assign WRITE_ERR = err_q;
`else
    logic unused_bresp;
    logic unused_err;
    assign unused_bresp = ^M_AXI_BRESP;
    assign unused_err   = err_q;
    assign b_fail       = 1'b0;
    assign WRITE_ERR    = 1'b0;
`endif

    assign M_AXI_AWID    = 1'b0;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = AXI_CACHE_BUF;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWBURST = AXI_BURST_INCR;
    assign M_AXI_AWLEN   = LAST_BEAT;
    assign M_AXI_AWSIZE  = 3'($clog2(C_M_AXI_DATA_WIDTH / 8));
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_AWADDR  = BASE_ADDR + offset;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign WRITE_DONE    = done_q;

    // FWFT FIFO head goes straight onto the W channel
    assign in_data      = (state == S_DATA);
    assign last_beat    = (beat == LAST_BEAT);
    assign M_AXI_WDATA  = rd_data;
    assign M_AXI_WVALID = in_data & empty_n;
    assign M_AXI_WLAST  = in_data & last_beat;
    assign r_en         = M_AXI_WVALID & M_AXI_WREADY;
    assign w_hs         = r_en;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state     <= S_IDLE;
            beat      <= 8'd0;
            burst_cnt <= 32'd0;
            total_q   <= 32'd0;
            offset    <= '0;
            awvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start_rise) begin
                        burst_cnt <= 32'd0;
                        offset    <= '0;
                        beat      <= 8'd0;
                        total_q   <= BURST_ONE_FRAME_TOTAL;
                        err_q     <= 1'b0;
                        if (BURST_ONE_FRAME_TOTAL == 32'd0) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state     <= S_ADDR;
                            awvalid_q <= 1'b1;
                        end
                    end
                end
                S_ADDR: begin
                    if (M_AXI_AWREADY) begin
                        awvalid_q <= 1'b0;
                        state     <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_hs) begin
                        if (last_beat) begin
                            beat     <= 8'd0;
                            bready_q <= 1'b1;
                            state    <= S_RESP;
                        end else begin
                            beat <= beat + 8'd1;
                        end
                    end
                end
                S_RESP: begin
                    if (M_AXI_BVALID) begin
                        bready_q  <= 1'b0;
                        burst_cnt <= burst_cnt + 32'd1;
                        offset    <= offset + BURST_BYTES;
                        if (b_fail) begin
                            err_q <= 1'b1;
                        end
                        if (b_fail || (burst_cnt + 32'd1 == total_q)) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state     <= S_ADDR;
                            awvalid_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
